// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of an 8N1 serializer.
// The CPU pushes bytes with wr_en; the serializer pops the head whenever it is idle,
// or on the last stop-bit cycle so that queued frames follow each other with no gap.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          ovr_clr,
    output logic          tx_full,
    output logic          tx_empty,
    output logic          tx_busy,
    output logic          tx_ovr,
    output logic [AW:0]   fifo_count,
    output logic          tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Serializer state (state_q is the observable FSM state for checkers)
    state_t         state_q;
    logic [CW-1:0]  baud_cnt_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic           tx_q;

    // FIFO state
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           ovr_q, ovr_d;

    logic           fifo_full;
    logic           fifo_empty;
    logic           baud_last;
    logic           push;
    logic           pop;
    logic [7:0]     head_data;

    assign fifo_full  = (count_q == DEPTH_CNT);
    assign fifo_empty = (count_q == '0);
    assign baud_last  = (baud_cnt_q == BAUD_LAST);
    assign head_data  = mem_q[rd_ptr_q];

    // Full is taken from the registered count, so a pop in the same cycle never frees a slot for a write.
    assign push = wr_en && !fifo_full;
    assign pop  = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_STOP && baud_last));

    // FIFO next-state: pointers, occupancy and the sticky overrun flag (set beats clear)
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovr_d    = ovr_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);
        if (ovr_clr)             ovr_d = 1'b0;
        if (wr_en && fifo_full)  ovr_d = 1'b1;
    end

    // FIFO control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
        end
    end

    // FIFO storage; only slots between the pointers are ever read, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    // 8N1 serializer: start bit, 8 data bits LSB first, stop bit; tx is registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q    <= head_data;
                        baud_cnt_q <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= shift_q[0];
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        shift_q    <= shift_q >> 1;
                        bit_idx_q  <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        if (pop) begin
                            shift_q <= head_data;
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign tx_empty   = fifo_empty;
    assign tx_full    = fifo_full;
    assign tx_ovr     = ovr_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with CLKS_PER_BIT=10 and FIFO_DEPTH=4.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// Handshake: a byte is accepted on a rising edge where wr_en=1 and tx_full=0.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovr_clr;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;
  logic       tx_ovr;
  logic [2:0] fifo_count;
  logic       tx;

  uart_tx_fifo #(
    .CLK_FREQ  (1000),
    .BAUD      (100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .ovr_clr   (ovr_clr),
    .tx_full   (tx_full),
    .tx_empty  (tx_empty),
    .tx_busy   (tx_busy),
    .tx_ovr    (tx_ovr),
    .fifo_count(fifo_count),
    .tx        (tx)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected summary before 30000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic drain_rx(input int n);
    int waited;
    logic [7:0] want;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      while (rx_q.size() == 0 && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      if (rx_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx_timeout: got no frame, expected %02h", want);
      end else begin
        check("rx_byte", {24'd0, rx_q.pop_front()}, {24'd0, want});
      end
    end
  endtask

  // ---------------- line monitor: decodes 8N1 frames at mid-bit ----------------
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 5) check("mon_start_bit", {31'd0, tx}, 32'd0);
      else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5)
        mon_byte[(mon_cnt - 15) / 10] = tx;
      else if (mon_cnt == 95) begin
        check("mon_stop_bit", {31'd0, tx}, 32'd1);
        rx_q.push_back(mon_byte);
      end
      if (mon_cnt == 99) mon_active = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
    wr_data = 8'h00;
  endtask

  // ---------------- single-frame vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic [0:9] bits;        // line levels in time order: start, d0..d7, stop
    int         busy_cycles;
  } vec_t;

  vec_t vecs[5];
  int   busy_n;
  int   low_n;

  initial begin
    vecs[0] = '{data: 8'hA5, bits: 10'b0101001011, busy_cycles: 100};
    vecs[1] = '{data: 8'h00, bits: 10'b0000000001, busy_cycles: 100};
    vecs[2] = '{data: 8'hFF, bits: 10'b0111111111, busy_cycles: 100};
    vecs[3] = '{data: 8'h3C, bits: 10'b0001111001, busy_cycles: 100};
    vecs[4] = '{data: 8'h81, bits: 10'b0100000011, busy_cycles: 100};

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    ovr_clr = 1'b0;

    // Reset, then idle for 50 cycles
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("idle_tx",    {31'd0, tx},       32'd1);
    check("idle_busy",  {31'd0, tx_busy},  32'd0);
    check("idle_empty", {31'd0, tx_empty}, 32'd1);
    check("idle_full",  {31'd0, tx_full},  32'd0);
    check("idle_ovr",   {31'd0, tx_ovr},   32'd0);
    check("idle_count", {29'd0, fifo_count}, 32'd0);

    // Single frames: latency, bit timing, busy length
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(vecs[v].data);
      write_byte(vecs[v].data);                 // now half a cycle after write edge E
      check("lat_tx_before_pop", {31'd0, tx},         32'd1);
      check("lat_count_one",     {29'd0, fifo_count}, 32'd1);
      check("lat_not_empty",     {31'd0, tx_empty},   32'd0);
      @(negedge clk);                           // after E+1: popped, start bit on the line
      check("lat_tx_low",        {31'd0, tx},         32'd0);
      check("lat_busy",          {31'd0, tx_busy},    32'd1);
      check("lat_empty_again",   {31'd0, tx_empty},   32'd1);
      check("lat_count_zero",    {29'd0, fifo_count}, 32'd0);
      busy_n = 1;
      for (int k = 1; k < 200; k++) begin
        @(negedge clk);
        if ((k % 10) == 5) check("frame_bit", {31'd0, tx}, {31'd0, vecs[v].bits[k / 10]});
        if (!tx_busy) break;
        busy_n++;
      end
      check("frame_busy_cycles", busy_n, vecs[v].busy_cycles);
      drain_rx(1);
      repeat (5) @(negedge clk);
    end

    // Three back-to-back writes: contiguous frames, busy held throughout
    start_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hF0);
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk); wr_data = 8'h0F;
    @(negedge clk); wr_data = 8'hF0;
    @(negedge clk); wr_en = 1'b0;               // E+2.5 where E is the first write edge
    check("b2b_count", {29'd0, fifo_count}, 32'd2);
    busy_n = 0;
    for (int k = 0; k < 400; k++) begin
      if (k == 148) begin
        check("b2b_mid_not_empty", {31'd0, tx_empty},   32'd0);
        check("b2b_mid_count",     {29'd0, fifo_count}, 32'd1);
      end
      if (k == 199) check("b2b_empty_after_third_pop", {31'd0, tx_empty}, 32'd1);
      if (!tx_busy) break;
      busy_n++;
      @(negedge clk);
    end
    // busy from E+1 to E+301 is seen on negedges E+2.5 .. E+300.5
    check("b2b_busy_run", busy_n, 299);
    drain_rx(3);
    check("b2b_frame_count", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("b2b_gap_1_2", start_q[1] - start_q[0], 100);
      check("b2b_gap_2_3", start_q[2] - start_q[1], 100);
    end
    repeat (5) @(negedge clk);

    // Overrun: one byte in the shifter, four queued, sixth dropped
    exp_q.push_back(8'h11);
    write_byte(8'h11);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'h22 + 8'(i) * 8'h11;
      if (i < 4) exp_q.push_back(8'h22 + 8'(i) * 8'h11);
    end
    @(negedge clk);
    check("ovr_count", {29'd0, fifo_count}, 32'd4);
    check("ovr_full",  {31'd0, tx_full},    32'd1);
    check("ovr_flag",  {31'd0, tx_ovr},     32'd1);
    wr_data = 8'h77;                            // dropped write together with a clear
    ovr_clr = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    ovr_clr = 1'b0;
    check("ovr_set_beats_clr", {31'd0, tx_ovr},     32'd1);
    check("ovr_count_held",    {29'd0, fifo_count}, 32'd4);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_cleared",    {31'd0, tx_ovr},  32'd0);
    check("ovr_still_full", {31'd0, tx_full}, 32'd1);
    drain_rx(5);
    repeat (30) @(negedge clk);
    check("ovr_idle_after", {31'd0, tx_busy}, 32'd0);

    // Reset in the middle of a data bit with two bytes queued
    write_byte(8'h3C);
    write_byte(8'hC3);
    write_byte(8'h99);
    repeat (40) @(negedge clk);
    check("abort_pre_busy",  {31'd0, tx_busy},    32'd1);
    check("abort_pre_count", {29'd0, fifo_count}, 32'd2);
    rst = 1'b1;
    #1;
    check("abort_tx_high",  {31'd0, tx},         32'd1);
    check("abort_busy",     {31'd0, tx_busy},    32'd0);
    check("abort_empty",    {31'd0, tx_empty},   32'd1);
    check("abort_count",    {29'd0, fifo_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    low_n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_n++;
    end
    check("abort_line_quiet", low_n, 0);
    check("abort_no_frames",  rx_q.size(), 0);
    exp_q.push_back(8'h81);
    write_byte(8'h81);
    drain_rx(1);
    repeat (10) @(negedge clk);

    // Write landing on the same edge where STOP pops the last queued byte
    exp_q.push_back(8'hC5);
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h7E);
    write_byte(8'hC5);                          // edge E, now E+0.5
    write_byte(8'h3A);                          // edge E+2, now E+2.5
    repeat (98) @(negedge clk);                 // E+100.5: last STOP cycle of first frame
    check("pp_count_before", {29'd0, fifo_count}, 32'd1);
    wr_en   = 1'b1;
    wr_data = 8'h7E;
    @(negedge clk);                             // E+101.5
    wr_en   = 1'b0;
    check("pp_count_after", {29'd0, fifo_count}, 32'd1);
    check("pp_tx_start",    {31'd0, tx},         32'd0);
    check("pp_busy",        {31'd0, tx_busy},    32'd1);
    drain_rx(3);
    repeat (20) @(negedge clk);
    check("end_empty", {31'd0, tx_empty}, 32'd1);
    check("end_tx",    {31'd0, tx},       32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
